// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, I-cache req/ack, skid buffer, redirect drop
// Optional macro IF_PERF_CNT_EN adds saturating fetch-wait and redirect counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_if_i,
  input  logic        flush_id_i,
  input  logic [1:0]  pc_taken_i,
  input  logic [31:0] target_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ack_i,
  input  logic [31:0] icache_rdata_i,
  output logic [31:0] inst_id_o,
  output logic [31:0] pc_id_o,
  output logic        valid_id_o,
  output logic        fetch_wait_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_wait_cyc_o,
  output logic [31:0] perf_redirect_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        req_q;
  logic        buf_valid_q;
  logic [31:0] buf_inst_q;
  logic [31:0] buf_pc_q;

  logic        redirect;
  logic [31:0] target_word;
  logic [31:0] pc_next;
  logic        load_fetch;
  logic        load_buf;
  logic        unused_target_bits;

  assign redirect           = (pc_taken_i == 2'b01) || (pc_taken_i == 2'b10);
  assign target_word        = {target_i[31:2], 2'b00};
  assign unused_target_bits = ^target_i[1:0];
  assign pc_next            = pc_q + 32'd4;

  assign icache_req_o  = req_q;
  assign icache_addr_o = req_addr_q;
  assign fetch_wait_o  = ((state_q == S_FETCH) || (state_q == S_DROP)) && !icache_ack_i;

  // A word reaches IF/ID either straight from the cache or from the skid buffer.
  assign load_fetch = (state_q == S_FETCH) && icache_ack_i && !redirect && !stall_if_i;
  assign load_buf   = (state_q == S_HOLD) && buf_valid_q && !redirect && !stall_if_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_pc_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          if (redirect) begin
            pc_q       <= target_word;
            req_addr_q <= target_word;
          end
        end
        S_FETCH: begin
          if (redirect) begin
            pc_q <= target_word;
            // An open request must keep its address, so the stale reply is drained in S_DROP.
            if (icache_ack_i) req_addr_q <= target_word;
            else              state_q    <= S_DROP;
          end else if (icache_ack_i) begin
            pc_q <= pc_next;
            if (stall_if_i) begin
              buf_valid_q <= 1'b1;
              buf_inst_q  <= icache_rdata_i;
              buf_pc_q    <= req_addr_q;
              req_q       <= 1'b0;
              state_q     <= S_HOLD;
            end else begin
              req_addr_q <= pc_next;
            end
          end
        end
        S_HOLD: begin
          if (redirect || !stall_if_i) begin
            buf_valid_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
            pc_q        <= redirect ? target_word : pc_q;
            req_addr_q  <= redirect ? target_word : pc_q;
          end
        end
        S_DROP: begin
          if (redirect) pc_q <= target_word;
          if (icache_ack_i) begin
            state_q    <= S_FETCH;
            req_addr_q <= redirect ? target_word : pc_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_id_o  <= NOP_INST;
      pc_id_o    <= 32'd0;
      valid_id_o <= 1'b0;
    end else if (flush_id_i) begin
      inst_id_o  <= NOP_INST;
      valid_id_o <= 1'b0;
    end else if (stall_if_i) begin
      inst_id_o  <= inst_id_o;
      valid_id_o <= valid_id_o;
    end else if (load_fetch) begin
      inst_id_o  <= icache_rdata_i;
      pc_id_o    <= req_addr_q;
      valid_id_o <= 1'b1;
    end else if (load_buf) begin
      inst_id_o  <= buf_inst_q;
      pc_id_o    <= buf_pc_q;
      valid_id_o <= 1'b1;
    end else begin
      inst_id_o  <= NOP_INST;
      valid_id_o <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_wait_cyc_o <= 32'd0;
      perf_redirect_o <= 32'd0;
    end else begin
      if (fetch_wait_o && (perf_wait_cyc_o != 32'hFFFF_FFFF))
        perf_wait_cyc_o <= perf_wait_cyc_o + 32'd1;
      if (redirect && (perf_redirect_o != 32'hFFFF_FFFF))
        perf_redirect_o <= perf_redirect_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed scenarios plus random program-order scoreboard for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        stall, flush, icache_ack;
  logic [1:0]  taken;
  logic [31:0] target, rdata;
  logic        icache_req_o, valid_id_o, fetch_wait_o;
  logic [31:0] icache_addr_o, inst_id_o, pc_id_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_wait_cyc_o, perf_redirect_o, perf_base;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  if_fetch_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_if_i(stall), .flush_id_i(flush),
    .pc_taken_i(taken), .target_i(target), .icache_req_o(icache_req_o),
    .icache_addr_o(icache_addr_o), .icache_ack_i(icache_ack), .icache_rdata_i(rdata),
    .inst_id_o(inst_id_o), .pc_id_o(pc_id_o), .valid_id_o(valid_id_o),
    .fetch_wait_o(fetch_wait_o)
`ifdef IF_PERF_CNT_EN
    , .perf_wait_cyc_o(perf_wait_cyc_o), .perf_redirect_o(perf_redirect_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic id_chk(input string tag, input logic [31:0] pc, input logic v);
    chk({tag, "_valid"}, {31'd0, valid_id_o}, {31'd0, v});
    chk({tag, "_inst"}, inst_id_o, v ? pc : NOP);
    if (v) chk({tag, "_pc"}, pc_id_o, pc);
  endtask

  // Directed phase: the cache returns the fetch address as the instruction word.
  task automatic drive(input logic a, input logic s, input logic f, input logic [1:0] t,
                       input logic [31:0] tg);
    icache_ack = a; stall = s; flush = f; taken = t; target = tg;
    rdata = icache_addr_o;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5EED_0F0F;
  endfunction

  logic [31:0] exp_pc, prev_addr, prev_inst, prev_pc, prev_target;
  logic        prev_open, prev_stall, prev_flush, prev_redir, prev_valid, redir;
  int          loads;

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 2'b00, 32'd0);
    #10;
    chk("rst_req", {31'd0, icache_req_o}, 32'd0);
    chk("rst_addr", icache_addr_o, 32'd0);
    chk("rst_wait", {31'd0, fetch_wait_o}, 32'd0);
    id_chk("rst_id", 32'd0, 1'b0);
    chk("rst_pc_id", pc_id_o, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_wait", perf_wait_cyc_o, 32'd0);
    chk("rst_perf_redir", perf_redirect_o, 32'd0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    step;
    chk("s1_first_req", {31'd0, icache_req_o}, 32'd1);
    chk("s1_first_addr", icache_addr_o, 32'd0);

    // Scenario 1: back-to-back hits
    drive(1, 0, 0, 2'b00, 0); chk("s1_wait_hit", {31'd0, fetch_wait_o}, 32'd0); step;
    id_chk("s1_id0", 32'h0, 1'b1);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("s1_id4", 32'h4, 1'b1);

    // Scenario 2: three-cycle miss at 0x8
`ifdef IF_PERF_CNT_EN
    perf_base = perf_wait_cyc_o;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 2'b00, 0);
      chk("s2_wait", {31'd0, fetch_wait_o}, 32'd1);
      chk("s2_addr_hold", icache_addr_o, 32'h8);
      step;
      id_chk("s2_bubble", 32'h0, 1'b0);
    end
    drive(1, 0, 0, 2'b00, 0); chk("s2_wait_ack", {31'd0, fetch_wait_o}, 32'd0); step;
    id_chk("s2_id8", 32'h8, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("s2_perf_wait", perf_wait_cyc_o - perf_base, 32'd3);
`endif
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("s2_idc", 32'hC, 1'b1);

    // Scenario 3: ack at 0x10 during a two-cycle stall
    drive(1, 1, 0, 2'b00, 0); step;
    chk("s3_hold_req", {31'd0, icache_req_o}, 32'd0);
    id_chk("s3_id_held", 32'hC, 1'b1);
    drive(0, 1, 0, 2'b00, 0); chk("s3_hold_wait", {31'd0, fetch_wait_o}, 32'd0); step;
    chk("s3_hold_req2", {31'd0, icache_req_o}, 32'd0);
    id_chk("s3_id_held2", 32'hC, 1'b1);
    drive(0, 0, 0, 2'b00, 0); step;
    id_chk("s3_id10", 32'h10, 1'b1);
    chk("s3_next_req", {31'd0, icache_req_o}, 32'd1);
    chk("s3_next_addr", icache_addr_o, 32'h14);

    // Scenario 4: redirect with a request open at 0x20
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 2'b00, 0); step;
    end
    chk("s4_open_addr", icache_addr_o, 32'h20);
`ifdef IF_PERF_CNT_EN
    perf_base = perf_redirect_o;
`endif
    drive(0, 0, 1, 2'b01, 32'h103); step;
    chk("s4_drop_req", {31'd0, icache_req_o}, 32'd1);
    chk("s4_drop_addr", icache_addr_o, 32'h20);
    id_chk("s4_flush", 32'h0, 1'b0);
    drive(0, 0, 0, 2'b00, 0); chk("s4_drop_wait", {31'd0, fetch_wait_o}, 32'd1); step;
    drive(1, 0, 0, 2'b00, 0); step;
    chk("s4_target_addr", icache_addr_o, 32'h100);
    id_chk("s4_stale_dropped", 32'h0, 1'b0);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("s4_id100", 32'h100, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("s4_perf_redir", perf_redirect_o - perf_base, 32'd1);
`endif

    // Scenario 5: redirect and stall together in S_HOLD
    drive(1, 1, 0, 2'b00, 0); step;
    chk("s5_hold_req", {31'd0, icache_req_o}, 32'd0);
    drive(0, 1, 1, 2'b10, 32'h200); step;
    chk("s5_req", {31'd0, icache_req_o}, 32'd1);
    chk("s5_addr", icache_addr_o, 32'h200);
    id_chk("s5_flush", 32'h0, 1'b0);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("s5_id200", 32'h200, 1'b1);

    // PC wrap at the top of the address space
    drive(1, 0, 1, 2'b01, 32'hFFFF_FFFE); step;
    chk("wrap_addr", icache_addr_o, 32'hFFFF_FFFC);
    id_chk("wrap_flush", 32'h0, 1'b0);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("wrap_top", 32'hFFFF_FFFC, 1'b1);
    chk("wrap_addr0", icache_addr_o, 32'h0);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("wrap_zero", 32'h0, 1'b1);

    // Scenario 6: reset asserted mid-request
    drive(0, 0, 0, 2'b00, 0);
    chk("s6_open", icache_addr_o, 32'h4);
    #1 rst_ni = 1'b0;
    #1;
    chk("s6_req", {31'd0, icache_req_o}, 32'd0);
    chk("s6_addr", icache_addr_o, 32'd0);
    chk("s6_wait", {31'd0, fetch_wait_o}, 32'd0);
    id_chk("s6_id", 32'h0, 1'b0);
    chk("s6_pc_id", pc_id_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    step;
    chk("s6_restart_addr", icache_addr_o, 32'd0);
    drive(1, 0, 0, 2'b00, 0); step;
    id_chk("s6_id0", 32'h0, 1'b1);

    // Random phase: every instruction entering ID must follow program order
    exp_pc = 32'h4; loads = 0;
    prev_open = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_open) begin
        chk("rnd_req_held", {31'd0, icache_req_o}, 32'd1);
        chk("rnd_addr_stable", icache_addr_o, prev_addr);
      end
      redir      = ($urandom_range(0, 9) == 0);
      taken      = redir ? ($urandom_range(0, 1) ? 2'b01 : 2'b10)
                         : ($urandom_range(0, 1) ? 2'b00 : 2'b11);
      target     = $urandom;
      flush      = redir;
      stall      = ($urandom_range(0, 3) == 0);
      icache_ack = ($urandom_range(0, 2) != 0);
      rdata      = icache_req_o ? word_at(icache_addr_o) : $urandom;
      #1;
      chk("rnd_fetch_wait", {31'd0, fetch_wait_o}, {31'd0, icache_req_o & ~icache_ack});
      prev_open = icache_req_o & ~icache_ack;
      prev_addr = icache_addr_o;
      prev_stall = stall; prev_flush = flush; prev_redir = redir; prev_target = target;
      prev_inst = inst_id_o; prev_pc = pc_id_o; prev_valid = valid_id_o;
      step;
      if (prev_flush) begin
        chk("rnd_flush_valid", {31'd0, valid_id_o}, 32'd0);
        chk("rnd_flush_inst", inst_id_o, NOP);
      end else if (prev_stall) begin
        chk("rnd_stall_inst", inst_id_o, prev_inst);
        chk("rnd_stall_pc", pc_id_o, prev_pc);
        chk("rnd_stall_valid", {31'd0, valid_id_o}, {31'd0, prev_valid});
      end else if (valid_id_o) begin
        chk("rnd_order_pc", pc_id_o, exp_pc);
        chk("rnd_order_inst", inst_id_o, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        loads++;
      end else begin
        chk("rnd_bubble_inst", inst_id_o, NOP);
      end
      if (prev_redir) exp_pc = {prev_target[31:2], 2'b00};
    end
    chk("rnd_progress", {31'd0, loads > 300}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
